// File: rtl/branch_predictor_pkg.sv
// Shared types for the front-end branch predictor: counter encoding, BTB entry, saturating update.
package bp_pkg;
  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t SNT = 2'b00;
  localparam bp_cnt_t WNT = 2'b01;
  localparam bp_cnt_t WT  = 2'b10;
  localparam bp_cnt_t ST  = 2'b11;

  localparam logic [2:0] BRANCH_TYPE_JAL = 3'b111;

  // Widest tag (ENTRIES=4); narrower tags are stored zero-extended.
  localparam int TAG_MAX_W = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic bp_cnt_t sat_update(input bp_cnt_t cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : bp_cnt_t'(cnt + 2'd1);
    return (cnt == SNT) ? SNT : bp_cnt_t'(cnt - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, resolution update and perf-counter signals between fetch/branch_unit and the predictor.
interface branch_predictor_if;
  logic        fetch_valid;
  logic        fetch_stall;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        predicted_taken;
  logic [31:0] predicted_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_mispredict;
  logic [31:0] perf_mispredicts;

  modport master (
    output fetch_valid, fetch_stall, fetch_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict,
    input  pred_valid, pred_hit, predicted_taken, predicted_target, perf_mispredicts
  );

  modport slave (
    input  fetch_valid, fetch_stall, fetch_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict,
    output pred_valid, pred_hit, predicted_taken, predicted_target, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor_counter_table.sv
// ENTRIES x 2-bit direction counters: one async read port, one load-or-saturate write port.
module bp_counter_table import bp_pkg::*; #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bp_cnt_t          rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_load_i,
  input  bp_cnt_t          wr_val_i,
  input  logic             wr_taken_i
);
  // Contents are meaningless until the matching BTB entry is valid, so no reset.
  bp_cnt_t cnt_q [ENTRIES];

  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (wr_en_i)
      cnt_q[wr_idx_i] <= wr_load_i ? wr_val_i : sat_update(cnt_q[wr_idx_i], wr_taken_i);
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit BHT; one-cycle registered prediction, trained by branch_unit resolutions.
module branch_predictor import bp_pkg::*; #(
  parameter int ENTRIES = 64
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t btb_q [ENTRIES];

  logic        pred_valid_q, pred_hit_q, pred_taken_q;
  logic [31:0] pred_target_q, perf_q;
  logic        pred_hit_d, pred_taken_d;
  logic [31:0] pred_target_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  btb_entry_t       f_ent, u_ent;
  bp_cnt_t          f_cnt;
  logic             u_hit, u_taken_eff, upd_en, btb_we, ct_we, ct_load;
  bp_cnt_t          ct_val;
  logic             unused_pc_bits;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[31:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  assign f_ent = btb_q[f_idx];
  assign u_ent = btb_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == TAG_MAX_W'(u_tag));

  // Every taken resolution writes the BTB: a hit refreshes the target, a miss allocates.
  assign u_taken_eff = bus.upd_taken || bus.upd_is_jump;
  assign upd_en      = bus.upd_valid && !rst;
  assign btb_we      = upd_en && u_taken_eff;
  assign ct_we       = upd_en && (u_hit || u_taken_eff);
  assign ct_load     = !u_hit || bus.upd_is_jump;
  assign ct_val      = bus.upd_is_jump ? ST : WT;

  bp_counter_table #(.ENTRIES(ENTRIES)) u_bht (
    .clk        (clk),
    .rd_idx_i   (f_idx),
    .rd_cnt_o   (f_cnt),
    .wr_en_i    (ct_we),
    .wr_idx_i   (u_idx),
    .wr_load_i  (ct_load),
    .wr_val_i   (ct_val),
    .wr_taken_i (bus.upd_taken)
  );

  always_comb begin
    pred_hit_d    = f_ent.valid && (f_ent.tag == TAG_MAX_W'(f_tag));
    pred_taken_d  = pred_hit_d && f_cnt[1];
    pred_target_d = pred_taken_d ? f_ent.target : bus.fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (btb_we) begin
      btb_q[u_idx] <= '{valid: 1'b1, tag: TAG_MAX_W'(u_tag), target: bus.upd_target};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      perf_q        <= '0;
    end else begin
      if (!bus.fetch_stall) begin
        pred_valid_q <= bus.fetch_valid;
        if (bus.fetch_valid) begin
          pred_hit_q    <= pred_hit_d;
          pred_taken_q  <= pred_taken_d;
          pred_target_q <= pred_target_d;
        end
      end
      if (bus.upd_valid && bus.upd_mispredict) perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.pred_valid       = pred_valid_q;
  assign bus.pred_hit         = pred_hit_q;
  assign bus.predicted_taken  = pred_taken_q;
  assign bus.predicted_target = pred_target_q;
  assign bus.perf_mispredicts = perf_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bus ();

  branch_predictor #(.ENTRIES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        pv, hit, tk;
    logic [31:0] tgt, perf;
  } exp_t;

  exp_t        sbq[$];
  logic        chk  = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] perf_exp = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) pend <= chk;

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL check%0d scoreboard empty while output presented", checks);
      end else begin
        e = sbq.pop_front();
        if ({bus.pred_valid, bus.pred_hit, bus.predicted_taken, bus.predicted_target, bus.perf_mispredicts}
            !== {e.pv, e.hit, e.tk, e.tgt, e.perf}) begin
          errors++;
          $display("FAIL check%0d got pv=%b hit=%b tk=%b tgt=%h perf=%0d, want pv=%b hit=%b tk=%b tgt=%h perf=%0d",
                   checks, bus.pred_valid, bus.pred_hit, bus.predicted_taken, bus.predicted_target,
                   bus.perf_mispredicts, e.pv, e.hit, e.tk, e.tgt, e.perf);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.fetch_valid = 1'b0; bus.fetch_stall = 1'b0; bus.fetch_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    bus.upd_is_jump = 1'b0; bus.upd_mispredict = 1'b0;
    rst = 1'b0; chk = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic expect_out(input logic pv, input logic hit, input logic tk, input logic [31:0] tgt);
    exp_t e;
    e.pv = pv; e.hit = hit; e.tk = tk; e.tgt = tgt; e.perf = perf_exp;
    sbq.push_back(e);
    chk = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic stall);
    bus.fetch_valid = 1'b1; bus.fetch_pc = pc; bus.fetch_stall = stall;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic jump, input logic misp);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tgt;
    bus.upd_is_jump = jump; bus.upd_mispredict = misp;
    if (misp) perf_exp++;
  endtask

  task automatic lk(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    fetch(pc, 1'b0);
    expect_out(1'b1, hit, tk, tgt);
    step();
  endtask

  task automatic u(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                   input logic jump, input logic misp);
    upd(pc, tk, tgt, jump, misp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d items pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    expect_out(1'b0, 1'b0, 1'b0, 32'h0);
    step();

    lk(32'h1000, 1'b0, 1'b0, 32'h1004);
    u(32'h1000, 1'b1, 32'h1064, 1'b0, 1'b1);
    lk(32'h1000, 1'b1, 1'b1, 32'h1064);

    // Hysteresis: WT -> WNT -> SNT -> SNT, then climb and saturate at ST.
    u(32'h1000, 1'b0, 32'h0, 1'b0, 1'b1);
    lk(32'h1000, 1'b1, 1'b0, 32'h1004);
    u(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b0, 32'h1004);
    u(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b0, 32'h1004);
    u(32'h1000, 1'b1, 32'h1064, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b0, 32'h1004);
    u(32'h1000, 1'b1, 32'h1064, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b1, 32'h1064);
    u(32'h1000, 1'b1, 32'h1064, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b1, 32'h1064);
    u(32'h1000, 1'b1, 32'h1064, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b1, 32'h1064);
    u(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    lk(32'h1000, 1'b1, 1'b1, 32'h1064);

    // Same-cycle update and lookup sees the pre-update counter.
    upd(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h1000, 1'b0);
    expect_out(1'b1, 1'b1, 1'b1, 32'h1064);
    step();
    lk(32'h1000, 1'b1, 1'b0, 32'h1004);

    // Jump allocation at the same index evicts 0x1000.
    u(32'h2000, 1'b1, 32'h3000, 1'b1, 1'b0);
    lk(32'h2000, 1'b1, 1'b1, 32'h3000);
    lk(32'h1000, 1'b0, 1'b0, 32'h1004);
    u(32'h4000, 1'b0, 32'h0, 1'b0, 1'b0);
    lk(32'h4000, 1'b0, 1'b0, 32'h4004);
    lk(32'h2000, 1'b1, 1'b1, 32'h3000);

    u(32'h1000, 1'b1, 32'h1064, 1'b0, 1'b0);
    u(32'h1100, 1'b1, 32'h1200, 1'b0, 1'b0);
    lk(32'h1000, 1'b0, 1'b0, 32'h1004);
    lk(32'h1100, 1'b1, 1'b1, 32'h1200);
    lk(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Stall holds every output even while a different PC is presented.
    lk(32'h1100, 1'b1, 1'b1, 32'h1200);
    for (int i = 0; i < 3; i++) begin
      fetch(32'h2000, 1'b1);
      expect_out(1'b1, 1'b1, 1'b1, 32'h1200);
      step();
    end
    bus.fetch_stall = 1'b1;
    expect_out(1'b1, 1'b1, 1'b1, 32'h1200);
    step();
    expect_out(1'b0, 1'b1, 1'b1, 32'h1200);
    step();

    u(32'h1004, 1'b1, 32'h5000, 1'b1, 1'b1);
    lk(32'h1004, 1'b1, 1'b1, 32'h5000);
    u(32'h1004, 1'b1, 32'h6000, 1'b1, 1'b0);
    lk(32'h1004, 1'b1, 1'b1, 32'h6000);

    // Reset with a lookup and an update in flight.
    fetch(32'h1100, 1'b0);
    upd(32'h1008, 1'b1, 32'h7000, 1'b0, 1'b1);
    rst = 1'b1;
    perf_exp = 0;
    expect_out(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    lk(32'h1100, 1'b0, 1'b0, 32'h1104);
    lk(32'h1004, 1'b0, 1'b0, 32'h1008);
    lk(32'h1008, 1'b0, 1'b0, 32'h100C);

    repeat (3) step();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain %0d expected outputs never presented, want 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
